// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory load/store controller.
// Size codes match the encoding on the requester ports.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWrite,
    StResp
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int unsigned NPORT = 2;

  // Illegal size code or an offset not aligned to the access size.
  function automatic logic bad_align(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Requester and memory-side bus of the load/store controller.
// slave = controller view, master = requester/memory view.
interface dmem_ctrl_if
  import dmem_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
);

  logic [NPORT-1:0]       req;
  logic [NPORT-1:0]       we;
  logic [2*NPORT-1:0]     size;
  logic [NPORT-1:0]       uns;
  logic [NPORT*WIDTH-1:0] addr;
  logic [NPORT*WIDTH-1:0] wdata;
  logic [NPORT-1:0]       ack;
  logic                   err;
  logic [WIDTH-1:0]       rdata;
  logic                   busy;
  logic [AW-1:0]          mem_addr;
  logic                   mem_wr;
  logic [WIDTH-1:0]       mem_wdata;
  logic [WIDTH-1:0]       mem_rdata;

  modport slave (
    input  req, we, size, uns, addr, wdata, mem_rdata,
    output ack, err, rdata, busy, mem_addr, mem_wr, mem_wdata
  );

  modport master (
    output req, we, size, uns, addr, wdata, mem_rdata,
    input  ack, err, rdata, busy, mem_addr, mem_wr, mem_wdata
  );

endinterface

// File: rtl/dmem_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge.
// Purely combinational; only WIDTH = 32 is supported.
module dmem_align
  import dmem_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       off,
  input  logic [1:0]       size,
  input  logic             uns,
  output logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] old_word,
  input  logic [15:0]      new_data,
  output logic [WIDTH-1:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[8*off +: 8];
    lane_h = word[16*off[1] +: 16];
    case (size)
      SZ_B:    load_val = {{(WIDTH-8){lane_b[7] & ~uns}}, lane_b};
      SZ_H:    load_val = {{(WIDTH-16){lane_h[15] & ~uns}}, lane_h};
      default: load_val = word;
    endcase
  end

  always_comb begin
    merged = old_word;
    case (size)
      SZ_B:    merged[8*off +: 8] = new_data[7:0];
      SZ_H:    merged[16*off[1] +: 16] = new_data;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port round-robin load/store controller in front of a single-port word memory.
// Sub-word stores are done as read (ACCESS) then merged write (WRITE).
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        rst,
  dmem_ctrl_if.slave bus
);

  state_e state_q, state_d;

  logic             ptr_q;
  logic             win, win_q;
  logic             grant;
  logic             sel_we, sel_uns, sel_err;
  logic [1:0]       sel_size;
  logic [WIDTH-1:0] sel_addr, sel_wdata;

  logic             we_q, uns_q, err_q;
  logic [1:0]       size_q;
  logic [AW+1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q, buf_q, rdata_q;
  logic [WIDTH-1:0] load_val, merged;

  assign grant = (state_q == StIdle) && (|bus.req);

  // Round-robin: on contention the port not served last wins.
  always_comb begin
    case (bus.req)
      2'b10:   win = 1'b1;
      2'b11:   win = ~ptr_q;
      default: win = 1'b0;
    endcase
    sel_we    = bus.we[win];
    sel_uns   = bus.uns[win];
    sel_size  = bus.size[2*win +: 2];
    sel_addr  = bus.addr[WIDTH*win +: WIDTH];
    sel_wdata = bus.wdata[WIDTH*win +: WIDTH];
    sel_err   = bad_align(sel_size, sel_addr[1:0]) ||
                (sel_addr[WIDTH-1:2] >= (WIDTH-2)'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (|bus.req) begin
          state_d = sel_err ? StResp : StAccess;
        end
      end
      StAccess: state_d = (we_q && size_q != SZ_W) ? StWrite : StResp;
      StWrite:  state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (grant) begin
        win_q   <= win;
        we_q    <= sel_we;
        uns_q   <= sel_uns;
        err_q   <= sel_err;
        size_q  <= sel_size;
        addr_q  <= sel_addr[AW+1:0];
        wdata_q <= sel_wdata;
        rdata_q <= '0;
      end
      if (state_q == StAccess) begin
        buf_q <= bus.mem_rdata;
        if (!we_q) begin
          rdata_q <= load_val;
        end
      end
      if (state_q == StResp) begin
        ptr_q <= win_q;
      end
    end
  end

  dmem_align #(
    .WIDTH(WIDTH)
  ) u_align (
    .word     (bus.mem_rdata),
    .off      (addr_q[1:0]),
    .size     (size_q),
    .uns      (uns_q),
    .load_val (load_val),
    .old_word (buf_q),
    .new_data (wdata_q[15:0]),
    .merged   (merged)
  );

  always_comb begin
    bus.ack       = '0;
    bus.err       = 1'b0;
    bus.rdata     = '0;
    bus.busy      = (state_q != StIdle);
    bus.mem_addr  = '0;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = '0;
    case (state_q)
      StAccess: begin
        bus.mem_addr = addr_q[AW+1:2];
        if (we_q && size_q == SZ_W) begin
          bus.mem_wr    = 1'b1;
          bus.mem_wdata = wdata_q;
        end
      end
      StWrite: begin
        bus.mem_addr  = addr_q[AW+1:2];
        bus.mem_wr    = 1'b1;
        bus.mem_wdata = merged;
      end
      StResp: begin
        bus.ack[win_q] = 1'b1;
        bus.err        = err_q;
        bus.rdata      = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: per-port drivers push expected responses from a
// word-array reference model; a negedge monitor pops and compares on every ack.
module tb_dmem_ctrl;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hold;
    logic        chk_lat;
    logic        abort;
  } cmd_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] lat;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  logic [4:0] last_wr_addr = '0;
  bit   abort_go = 0;
  bit   abort_done = 0;

  logic [31:0] mem     [32];
  logic [31:0] ref_mem [32];
  cmd_t cq0[$], cq1[$];
  exp_t eq0[$], eq1[$];
  int   ack_port[$], ack_cyc[$];

  dmem_ctrl_if #(.WIDTH(32), .DEPTH(32)) bus ();

  dmem_ctrl #(.WIDTH(32), .DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
  endfunction

  // Reference model: a plain word array, byte offsets and masks.
  function automatic exp_t model(input cmd_t c);
    exp_t e;
    int unsigned idx = c.addr >> 2;
    int unsigned off = c.addr % 4;
    int unsigned sh = 8 * off;
    logic [31:0] w, mask, v;
    e.rdata = 0;
    e.err = (c.size == 2'd3) || (c.size == 2'd1 && (off % 2) != 0) ||
            (c.size == 2'd2 && off != 0) || (idx >= 32);
    if (e.err) begin
      e.lat = 1;
      return e;
    end
    mask = (c.size == 2'd0) ? 32'hFF : (c.size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    w = ref_mem[idx[4:0]];
    if (!c.we) begin
      v = (w >> sh) & mask;
      if (!c.uns && c.size == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (!c.uns && c.size == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
      e.rdata = v;
      e.lat = 2;
    end else begin
      ref_mem[idx[4:0]] = (w & ~(mask << sh)) | ((c.wdata & mask) << sh);
      e.lat = (c.size == 2'd2) ? 2 : 3;
    end
    return e;
  endfunction

  function automatic bit pop_cmd(input int p, output cmd_t c);
    c = '0;
    if (p == 0 && cq0.size() > 0) begin c = cq0.pop_front(); return 1'b1; end
    if (p == 1 && cq1.size() > 0) begin c = cq1.pop_front(); return 1'b1; end
    return 1'b0;
  endfunction

  function automatic void push_exp(input int p, input exp_t e);
    if (p == 0) eq0.push_back(e);
    else eq1.push_back(e);
  endfunction

  function automatic void drop_exp(input int p);
    if (p == 0 && eq0.size() > 0) void'(eq0.pop_back());
    if (p == 1 && eq1.size() > 0) void'(eq1.pop_back());
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_drv
    cmd_t cur;
    exp_t ce;
    logic req_r;
    bit   have;
    int   n;
    bit   got;
    assign bus.req[g]             = req_r;
    assign bus.we[g]              = cur.we;
    assign bus.size[2*g +: 2]     = cur.size;
    assign bus.uns[g]             = cur.uns;
    assign bus.addr[32*g +: 32]   = cur.addr;
    assign bus.wdata[32*g +: 32]  = cur.wdata;

    initial begin
      req_r = 1'b0;
      cur = '0;
      forever begin
        @(negedge clk);
        have = pop_cmd(g, cur);
        while (have) begin
          req_r = 1'b1;
          ce = '0;
          if (!cur.abort) begin
            ce = model(cur);
            push_exp(g, ce);
          end
          n = 0;
          got = 0;
          while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (cur.abort) begin
              check("abort_busy_in_access", {31'd0, bus.busy}, 32'd1);
              abort_go = 1;
              wait (abort_done);
              got = 1;
            end else if (bus.ack[g]) begin
              got = 1;
            end
          end
          if (!cur.abort) begin
            if (!got) begin
              check($sformatf("p%0d_ack_timeout", g), {31'd0, bus.ack[g]}, 32'd1);
              drop_exp(g);
            end else if (cur.chk_lat) begin
              check($sformatf("p%0d_latency a=%0h", g, cur.addr), n, ce.lat);
            end
          end
          if (cur.hold && !cur.abort && pop_cmd(g, cur)) begin
            have = 1;
          end else begin
            req_r = 1'b0;
            have = 0;
          end
        end
      end
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_wr) begin
      wr_cnt++;
      last_wr_addr = bus.mem_addr;
    end
    for (int p = 0; p < 2; p++) begin
      if (bus.ack[p]) begin
        if ((p == 0 && eq0.size() == 0) || (p == 1 && eq1.size() == 0)) begin
          check($sformatf("p%0d_unexpected_ack", p), {31'd0, bus.ack[p]}, 32'd0);
        end else begin
          e = (p == 0) ? eq0.pop_front() : eq1.pop_front();
          check($sformatf("p%0d_err", p), {31'd0, bus.err}, {31'd0, e.err});
          check($sformatf("p%0d_rdata", p), bus.rdata, e.rdata);
          ack_port.push_back(p);
          ack_cyc.push_back(cyc);
        end
      end
    end
  end

  function automatic cmd_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata);
    cmd_t c = '0;
    c.we = we; c.size = size; c.uns = uns; c.addr = addr; c.wdata = wdata;
    c.chk_lat = 1'b1;
    return c;
  endfunction

  function automatic cmd_t rand_cmd(input int p);
    cmd_t c = '0;
    c.we    = 1'($urandom_range(0, 1));
    c.size  = 2'($urandom_range(0, 3));
    c.uns   = 1'($urandom_range(0, 1));
    c.wdata = $urandom;
    c.hold  = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 9) == 0) c.addr = 32'h80 + $urandom_range(0, 255);
    else c.addr = 32'(p * 64) + $urandom_range(0, 63);
    if ($urandom_range(0, 3) != 0) begin
      if (c.size == 2'd1) c.addr[0] = 1'b0;
      if (c.size == 2'd2) c.addr[1:0] = 2'b00;
    end
    return c;
  endfunction

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((cq0.size() != 0 || cq1.size() != 0 || eq0.size() != 0 || eq1.size() != 0 ||
            bus.req != 2'b00 || bus.busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check({nm, "_idle_timeout"}, {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
  endtask

  function automatic int mem_diff();
    int bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
    return bad;
  endfunction

  function automatic logic outs_nonzero();
    return |{bus.ack, bus.err, bus.rdata, bus.busy, bus.mem_wr, bus.mem_addr, bus.mem_wdata};
  endfunction

  initial begin
    int wc;
    int n;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    #1;
    check("reset_outputs_zero", {31'd0, outs_nonzero()}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Randomized concurrent traffic; ports touch disjoint word ranges.
    for (int i = 0; i < 40; i++) begin
      cq0.push_back(rand_cmd(0));
      cq1.push_back(rand_cmd(1));
    end
    wait_idle("random");
    check("random_mem_image_diffs", mem_diff(), 0);

    // Word store then load, port 0.
    wc = wr_cnt;
    cq0.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF));
    wait_idle("wstore");
    check("wstore_wr_pulses", wr_cnt - wc, 1);
    check("wstore_mem_addr", {27'd0, last_wr_addr}, 32'd4);
    check("wstore_mem4", mem[4], 32'hDEAD_BEEF);
    cq0.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0));
    wait_idle("wload");

    // Byte read-modify-write and sub-word loads.
    wc = wr_cnt;
    cq0.push_back(mk(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FF5A));
    wait_idle("bstore");
    check("bstore_wr_pulses", wr_cnt - wc, 1);
    check("bstore_mem4", mem[4], 32'hDEAD_5AEF);
    cq0.push_back(mk(1'b0, 2'b00, 1'b0, 32'h11, 32'h0));
    cq0.push_back(mk(1'b0, 2'b01, 1'b0, 32'h12, 32'h0));
    cq0.push_back(mk(1'b0, 2'b01, 1'b1, 32'h12, 32'h0));
    cq0.push_back(mk(1'b0, 2'b00, 1'b0, 32'h13, 32'h0));
    cq0.push_back(mk(1'b1, 2'b01, 1'b0, 32'h16, 32'hABCD_8001));
    cq0.push_back(mk(1'b0, 2'b10, 1'b0, 32'h14, 32'h0));
    wait_idle("subword");

    // Rejected requests: no memory write, memory unchanged.
    wc = wr_cnt;
    cq0.push_back(mk(1'b0, 2'b01, 1'b0, 32'h03, 32'h0));
    cq0.push_back(mk(1'b1, 2'b10, 1'b0, 32'h06, 32'h1234_5678));
    cq0.push_back(mk(1'b1, 2'b11, 1'b0, 32'h08, 32'h1234_5678));
    cq0.push_back(mk(1'b0, 2'b10, 1'b0, 32'h80, 32'h0));
    cq0.push_back(mk(1'b1, 2'b00, 1'b0, 32'h7C, 32'h55));
    cq0.push_back(mk(1'b1, 2'b10, 1'b0, 32'h84, 32'h55));
    wait_idle("errors");
    check("errors_wr_pulses", wr_cnt - wc, 1);
    check("errors_mem_image_diffs", mem_diff(), 0);

    // Reset during ACCESS of a byte store.
    begin
      cmd_t c = mk(1'b1, 2'b00, 1'b0, 32'h21, 32'hA5);
      c.abort = 1'b1;
      cq0.push_back(c);
    end
    n = 0;
    while (!abort_go && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_access", {31'd0, abort_go}, 32'd1);
    #1;
    rst = 1'b0;
    wc = wr_cnt;
    #1;
    check("rst_mid_rmw_outputs_zero", {31'd0, outs_nonzero()}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_held_outputs_zero", {31'd0, outs_nonzero()}, 32'd0);
    end
    abort_done = 1;
    @(negedge clk);
    rst = 1'b1;
    check("rst_no_mem_wr", wr_cnt - wc, 0);
    check("rst_target_word", mem[8], ref_mem[8]);

    // Both ports loading back to back: strict alternation, port 0 first.
    ack_port.delete();
    ack_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      cmd_t c0 = mk(1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0);
      cmd_t c1 = mk(1'b0, 2'b10, 1'b0, 32'(64 + 4 * i), 32'h0);
      c0.hold = 1'b1; c0.chk_lat = 1'b0;
      c1.hold = 1'b1; c1.chk_lat = 1'b0;
      cq0.push_back(c0);
      cq1.push_back(c1);
    end
    wait_idle("arb");
    check("arb_ack_count", ack_port.size(), 8);
    for (int k = 0; k < ack_port.size(); k++) begin
      check($sformatf("arb_port_%0d", k), ack_port[k], k % 2);
      if (k > 0) check($sformatf("arb_spacing_%0d", k), ack_cyc[k] - ack_cyc[k-1], 3);
    end
    check("final_mem_image_diffs", mem_diff(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
